// File: rtl/pkt_cls_pkg.sv
// Shared packet-classifier definitions: RIDS word layout, rule ID and rule
// bitmap types, used by the range match trees and the RIDS merge unit.
package pkt_cls_pkg;

    localparam int RIDS_WIDTH    = 32;
    localparam int SLOT_WIDTH    = 4;
    localparam int NUM_SLOTS     = 8;
    localparam int RULE_ID_WIDTH = 3;
    localparam int NUM_RULES     = 1 << RULE_ID_WIDTH;
    localparam int NUM_FIELDS    = 4;

    typedef logic [RULE_ID_WIDTH-1:0] rule_id_t;
    typedef logic [NUM_RULES-1:0]     rule_bmp_t;

    // One RIDS slot; the valid flag is the slot's most significant bit.
    typedef struct packed {
        logic     valid;
        rule_id_t id;
    } rids_slot_t;

    // Slot 0 is the most significant nibble of the word, so slot k sits at
    // element NUM_SLOTS-1-k of this packed array.
    typedef rids_slot_t [NUM_SLOTS-1:0] rids_word_t;

    // Index of the lowest set bit (highest-priority rule); 0 for an empty map.
    function automatic rule_id_t lowest_rule(input rule_bmp_t bmp);
        rule_id_t id;
        id = '0;
        for (int r = NUM_RULES - 1; r >= 0; r--) begin
            if (bmp[r]) id = rule_id_t'(r);
        end
        return id;
    endfunction

endpackage

// File: rtl/rids_decoder.sv
// Combinational decode of one RIDS word into a rule bitmap: bit r is set when
// any valid slot carries rule ID r.
module rids_decoder
    import pkt_cls_pkg::*;
(
    input  rids_word_t rids_i,
    output rule_bmp_t  bitmap_o
);

    // Mark each valid slot's rule; invalid slots are skipped, repeats merge.
    always_comb begin
        // NOTE: assign a default before the loop so every path drives the
        // output and no latch is inferred.
        bitmap_o = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (rids_i[s].valid) bitmap_o[rids_i[s].id] = 1'b1;
        end
    end

endmodule

// File: rtl/rids_merge_unit.sv
// Three-stage RIDS merge: decode each field's RIDS word to a rule bitmap,
// intersect the bitmaps, then encode hit flag and highest-priority rule ID.
// The whole pipeline freezes while a result waits on the consumer; delivered
// results and misses are counted in saturating statistics counters.
module rids_merge_unit #(
    parameter int NUM_FIELDS = pkt_cls_pkg::NUM_FIELDS,
    parameter int RIDS_WIDTH = pkt_cls_pkg::RIDS_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_FIELDS*RIDS_WIDTH-1:0] field_rids,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_hit,
    output pkt_cls_pkg::rule_id_t            out_rule_id,
    input  logic                             cnt_clr,
    output logic [CNT_WIDTH-1:0]             pkt_cnt,
    output logic [CNT_WIDTH-1:0]             miss_cnt
);

    import pkt_cls_pkg::*;

    logic                 stall;
    logic                 deliver;

    rule_bmp_t            field_bmp [NUM_FIELDS];

    logic                 s1_valid_q;
    rule_bmp_t            s1_bmp_q [NUM_FIELDS];

    logic                 s2_valid_q;
    rule_bmp_t            s2_and_q;
    rule_bmp_t            s2_and_d;

    logic                 out_valid_q;
    logic                 out_hit_q;
    logic                 out_hit_d;
    rule_id_t             out_rule_id_q;
    rule_id_t             out_rule_id_d;

    logic [CNT_WIDTH-1:0] pkt_cnt_q;
    logic [CNT_WIDTH-1:0] pkt_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q;
    logic [CNT_WIDTH-1:0] miss_cnt_d;

    // A held result blocks every stage; only then is input refused.
    assign stall    = out_valid_q && !out_ready;
    assign deliver  = out_valid_q && out_ready;
    assign in_ready = !stall;

    // Field 0 occupies the most significant word of the input bus.
    for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_dec
        rids_decoder u_dec (
            .rids_i   (field_rids[(NUM_FIELDS-f)*RIDS_WIDTH-1 -: RIDS_WIDTH]),
            .bitmap_o (field_bmp[f])
        );
    end

    // Intersect all field bitmaps held in stage 1.
    always_comb begin
        s2_and_d = '1;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            s2_and_d &= s1_bmp_q[f];
        end
    end

    // Encode stage 2's intersection; bubbles encode as a clean miss.
    always_comb begin
        out_hit_d     = s2_valid_q && (|s2_and_q);
        out_rule_id_d = out_hit_d ? lowest_rule(s2_and_q) : '0;
    end

    // Stage valid bits and the registered result advance together unless stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q    <= 1'b0;
            s2_valid_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_hit_q     <= 1'b0;
            out_rule_id_q <= '0;
        end else if (!stall) begin
            // NOTE: non-blocking assignments so every stage samples the
            // previous stage's value from before this clock edge.
            s1_valid_q    <= in_valid;
            s2_valid_q    <= s1_valid_q;
            out_valid_q   <= s2_valid_q;
            out_hit_q     <= out_hit_d;
            out_rule_id_q <= out_rule_id_d;
        end
    end

    // Bitmap data registers load only when their stage takes a real packet.
    always_ff @(posedge clk) begin
        // NOTE: no reset here; the valid bits alone decide whether this data
        // is meaningful, so resetting it would buy nothing.
        if (!stall && in_valid)   s1_bmp_q <= field_bmp;
        if (!stall && s1_valid_q) s2_and_q <= s2_and_d;
    end

    // Counter next state: clear has priority over a same-cycle delivery.
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (cnt_clr) begin
            pkt_cnt_d  = '0;
            miss_cnt_d = '0;
        end else if (deliver) begin
            if (pkt_cnt_q != '1)                pkt_cnt_d  = pkt_cnt_q + 1'b1;
            if (!out_hit_q && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
        end
    end

    // Statistics counter state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_hit     = out_hit_q;
    assign out_rule_id = out_rule_id_q;
    assign pkt_cnt     = pkt_cnt_q;
    assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_rids_merge_unit.sv
// Bench for rids_merge_unit. A set-based reference model predicts every
// accepted packet's result; a compare process checks outputs, handshakes and
// counters each cycle. Directed sequences pin latency, stalls, reset and
// counter saturation with literal values. A second instance with 3-bit
// counters runs in lockstep so saturation is reached quickly.
module tb_rids_merge_unit;

    localparam int NF    = 4;
    localparam int RW    = 32;
    localparam int CW    = 16;
    localparam int CW_S  = 3;
    localparam int MAX_M = (1 << CW) - 1;
    localparam int MAX_S = (1 << CW_S) - 1;

    typedef struct {
        logic       hit;
        logic [2:0] id;
    } exp_t;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [NF*RW-1:0] field_rids;
    logic             out_valid;
    logic             out_ready;
    logic             out_hit;
    logic [2:0]       out_rule_id;
    logic             cnt_clr;
    logic [CW-1:0]    pkt_cnt;
    logic [CW-1:0]    miss_cnt;

    logic             s_in_ready;
    logic             s_out_valid;
    logic             s_out_hit;
    logic [2:0]       s_out_rule_id;
    logic [CW_S-1:0]  s_pkt_cnt;
    logic [CW_S-1:0]  s_miss_cnt;

    int   n_vec;
    int   n_fail;
    int   n_deliv;
    int   m_pkt, m_miss, m_pkt_s, m_miss_s;
    exp_t q[$];
    bit   prev_stall;
    logic prev_hit;
    logic [2:0] prev_id;

    rids_merge_unit #(.NUM_FIELDS(NF), .RIDS_WIDTH(RW), .CNT_WIDTH(CW)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .field_rids  (field_rids),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_hit     (out_hit),
        .out_rule_id (out_rule_id),
        .cnt_clr     (cnt_clr),
        .pkt_cnt     (pkt_cnt),
        .miss_cnt    (miss_cnt)
    );

    rids_merge_unit #(.NUM_FIELDS(NF), .RIDS_WIDTH(RW), .CNT_WIDTH(CW_S)) u_dut_sat (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (s_in_ready),
        .field_rids  (field_rids),
        .out_valid   (s_out_valid),
        .out_ready   (out_ready),
        .out_hit     (s_out_hit),
        .out_rule_id (s_out_rule_id),
        .cnt_clr     (cnt_clr),
        .pkt_cnt     (s_pkt_cnt),
        .miss_cnt    (s_miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: per field, the set of rule IDs named by valid slots; the
    // result is the smallest rule present in every field's set.
    function automatic exp_t model(input logic [NF*RW-1:0] bus);
        exp_t          e;
        bit            present [NF][8];
        bit            all_fields;
        logic [RW-1:0] word;
        logic [3:0]    nib;
        e.hit = 1'b0;
        e.id  = 3'd0;
        for (int f = 0; f < NF; f++)
            for (int r = 0; r < 8; r++)
                present[f][r] = 1'b0;
        for (int f = 0; f < NF; f++) begin
            word = bus[(NF-f)*RW-1 -: RW];
            for (int s = 0; s < 8; s++) begin
                nib = word[RW-1-4*s -: 4];
                if (nib[3]) present[f][nib[2:0]] = 1'b1;
            end
        end
        for (int r = 0; r < 8; r++) begin
            all_fields = 1'b1;
            for (int f = 0; f < NF; f++)
                if (!present[f][r]) all_fields = 1'b0;
            if (all_fields && !e.hit) begin
                e.hit = 1'b1;
                e.id  = 3'(r);
            end
        end
        return e;
    endfunction

    // Packet i: every field names rule i+1; field 0 also names rule 7.
    function automatic logic [NF*RW-1:0] pat(input int i);
        logic [2:0] id;
        id = 3'(i + 1);
        return {1'b1, id, 4'hF, 24'h0, {3{1'b1, id, 28'h0}}};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Single packet on an idle pipeline with out_ready high: result visible
    // exactly three cycles after acceptance, counters updated one cycle later.
    task automatic one_packet(input string tag, input logic [NF*RW-1:0] bus,
                              input logic hit, input logic [2:0] id,
                              input int pkt, input int miss);
        cyc();
        in_valid   = 1'b1;
        field_rids = bus;
        cyc();
        in_valid   = 1'b0;
        @(negedge clk); check({tag, "_lat1_valid"}, out_valid, 0);
        @(negedge clk); check({tag, "_lat2_valid"}, out_valid, 0);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_hit"}, out_hit, hit);
        check({tag, "_rule_id"}, out_rule_id, id);
        @(negedge clk);
        check({tag, "_pkt_cnt"}, pkt_cnt, pkt);
        check({tag, "_miss_cnt"}, miss_cnt, miss);
        check({tag, "_drained"}, out_valid, 0);
    endtask

    // Cycle-by-cycle comparison against the reference model.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("rst_out_valid", out_valid, 0);
                check("rst_in_ready", in_ready, 1);
                check("rst_pkt_cnt", pkt_cnt, 0);
                check("rst_miss_cnt", miss_cnt, 0);
                check("rst_sat_out_valid", s_out_valid, 0);
                check("rst_sat_pkt_cnt", s_pkt_cnt, 0);
                check("rst_sat_miss_cnt", s_miss_cnt, 0);
                q.delete();
                m_pkt = 0; m_miss = 0; m_pkt_s = 0; m_miss_s = 0;
                prev_stall = 1'b0;
            end else begin
                check("in_ready_rule", in_ready, !(out_valid && !out_ready));
                check("sat_in_ready_rule", s_in_ready, !(s_out_valid && !out_ready));
                if (prev_stall) begin
                    check("stall_hold_valid", out_valid, 1);
                    check("stall_hold_hit", out_hit, prev_hit);
                    check("stall_hold_id", out_rule_id, prev_id);
                end
                check("pkt_cnt", pkt_cnt, m_pkt);
                check("miss_cnt", miss_cnt, m_miss);
                check("sat_pkt_cnt", s_pkt_cnt, m_pkt_s);
                check("sat_miss_cnt", s_miss_cnt, m_miss_s);
                if (out_valid || s_out_valid) begin
                    check("result_expected", q.size() > 0, 1);
                    if (q.size() > 0) begin
                        if (out_valid) begin
                            check("out_hit", out_hit, q[0].hit);
                            check("out_rule_id", out_rule_id, q[0].id);
                        end
                        if (s_out_valid) begin
                            check("sat_out_hit", s_out_hit, q[0].hit);
                            check("sat_out_rule_id", s_out_rule_id, q[0].id);
                        end
                    end
                end
                if (out_valid && out_ready && q.size() > 0) begin
                    e = q.pop_front();
                    n_deliv++;
                    if (cnt_clr) begin
                        m_pkt = 0; m_miss = 0; m_pkt_s = 0; m_miss_s = 0;
                    end else begin
                        if (m_pkt < MAX_M) m_pkt++;
                        if (m_pkt_s < MAX_S) m_pkt_s++;
                        if (!e.hit && m_miss < MAX_M) m_miss++;
                        if (!e.hit && m_miss_s < MAX_S) m_miss_s++;
                    end
                end else if (cnt_clr) begin
                    m_pkt = 0; m_miss = 0; m_pkt_s = 0; m_miss_s = 0;
                end
                if (in_valid && in_ready) q.push_back(model(field_rids));
                prev_stall = out_valid && !out_ready;
                prev_hit   = out_hit;
                prev_id    = out_rule_id;
            end
        end
    end

    // Hang guard.
    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish before 100000 ns");
        $fatal(1, "bench timeout");
    end

    initial begin
        int idx;
        int start;
        n_vec = 0; n_fail = 0; n_deliv = 0;
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        cnt_clr    = 1'b0;
        field_rids = '0;
        #1;
        check("init_out_valid", out_valid, 0);
        check("init_in_ready", in_ready, 1);
        check("init_out_rule_id", out_rule_id, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Result pattern coverage on an idle pipeline.
        one_packet("all_b9", {4{32'hB9000000}}, 1'b1, 3'd1, 1, 0);
        one_packet("disjoint", {32'hB0000000, 32'h90000000, 32'hB9000000, 32'hB9000000},
                   1'b0, 3'd0, 2, 1);
        one_packet("slot0_invalid", {4{32'h3B000000}}, 1'b1, 3'd3, 3, 1);
        one_packet("dup_ids", {32'hFDA90000, 32'hCA0E0000, 32'hAAAA2000, 32'h7A000000},
                   1'b1, 3'd2, 4, 1);
        one_packet("invalid_only_match", {32'hFDA90000, 32'hCA0E0000, 32'h2C000000, 32'h7A000000},
                   1'b0, 3'd0, 5, 2);
        one_packet("field_all_invalid", {32'hB9000000, 32'hB9000000, 32'h01234567, 32'hB9000000},
                   1'b0, 3'd0, 6, 3);
        one_packet("rule0", {4{32'h8F000000}}, 1'b1, 3'd0, 7, 3);

        // Five back-to-back packets with the consumer stalling in cycles 4-7.
        cyc();
        idx   = 0;
        start = n_deliv;
        for (int c = 1; c <= 30; c++) begin
            out_ready = !(c >= 4 && c <= 7);
            in_valid  = (idx < 5);
            if (idx < 5) field_rids = pat(idx);
            @(negedge clk);
            check("stall_in_ready", in_ready, (c >= 4 && c <= 7) ? 0 : 1);
            if (in_valid && in_ready) idx++;
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stall_accepted", idx, 5);
        check("stall_delivered", n_deliv - start, 5);

        // Reset with three packets in flight.
        for (int i = 0; i < 3; i++) begin
            cyc();
            in_valid   = 1'b1;
            field_rids = pat(i + 1);
        end
        cyc();
        in_valid = 1'b0;
        check("inflight_out_valid", out_valid, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_pkt_cnt", pkt_cnt, 0);
        check("midrst_miss_cnt", miss_cnt, 0);
        check("midrst_in_ready", in_ready, 1);
        repeat (2) cyc();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_stale", out_valid, 0);
        end
        one_packet("post_rst", {4{32'hB9000000}}, 1'b1, 3'd1, 1, 0);

        // Ten misses: the 3-bit counters saturate, the 16-bit ones do not.
        cyc();
        in_valid   = 1'b1;
        field_rids = {32'hB9000000, 32'h00000000, 32'hB9000000, 32'hB9000000};
        repeat (9) cyc();
        cyc();
        in_valid = 1'b0;
        repeat (4) cyc();
        @(negedge clk);
        check("sat_main_pkt", pkt_cnt, 11);
        check("sat_main_miss", miss_cnt, 10);
        check("sat_small_pkt", s_pkt_cnt, 7);
        check("sat_small_miss", s_miss_cnt, 7);

        // Clear coincident with a delivery: clear wins.
        cyc();
        in_valid   = 1'b1;
        field_rids = {32'hB9000000, 32'h00000000, 32'hB9000000, 32'hB9000000};
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        cnt_clr = 1'b1;
        @(negedge clk);
        check("clr_deliver_valid", out_valid, 1);
        cyc();
        cnt_clr = 1'b0;
        @(negedge clk);
        check("clr_pkt_cnt", pkt_cnt, 0);
        check("clr_miss_cnt", miss_cnt, 0);
        check("clr_sat_pkt_cnt", s_pkt_cnt, 0);
        check("clr_sat_miss_cnt", s_miss_cnt, 0);

        repeat (5) cyc();
        check("all_results_delivered", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
